nn_stream_driver: RTL
=====================

Name: nn_stream_driver

Overview:
- Initiator side of the NN accelerator stream interface.
- Holds one RNN job in an internal buffer, written by the host through a simple config port:
  - weight matrices U, W, V: 3x3 each;
  - input sequence x: 3 steps x 3 elements.
- On start, drives the job into NN over in_valid_u/w/v/x + weight_*/data_x, then collects NN's out_valid/out result stream into a readable result buffer.
- Sits between the host/pattern logic and the NN core; replaces hand-written stimulus for system-level runs.

Parameters:
- DW, 32, IEEE-754 single word width (inst_sig_width+inst_exp_width+1).
- N_IN, 9, words per input stream (U, W, V, x each).
- N_OUT, 9, result words expected from NN.
- LAT_MAX, 100, max cycles from last sent word to first out_valid.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  write strobe for job buffer.
- cfg_sel  in  2  target buffer: 0=U, 1=W, 2=V, 3=x.
- cfg_addr  in  4  word index 0..8.
- cfg_data  in  DW  word to write.
- start  in  1  one-cycle pulse to launch a job.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when job ends (ok or error).
- err  out  1  sticky error flag: timeout or protocol violation; cleared on next accepted start.
- rd_addr  in  4  result index 0..8.
- rd_data  out  DW  result word, combinational read of result buffer.
- in_valid_u, in_valid_w, in_valid_v, in_valid_x  out  1  NN input valids.
- weight_u, weight_w, weight_v, data_x  out  DW  NN input data.
- out_valid  in  1  NN result valid.
- out  in  DW  NN result data.

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0;
  - job and result buffers cleared to 0;
  - FSM to IDLE;
  - counters to 0.
  - Reset mid-job aborts immediately; outputs drop to 0 asynchronously.
- FSM states: IDLE, SEND, WAIT, RECV, FIN.
- IDLE:
  - cfg_we writes buffer[cfg_sel][cfg_addr]; writes with cfg_addr>8 are ignored.
  - start=1 -> SEND next cycle, busy=1, err=0, idx=0.
- SEND:
  - Runs exactly N_IN consecutive cycles, idx 0..8.
  - All four in_valid_* high together; each data port = its buffer[idx].
  - Word order is row-major: U/W/V index = row*3+col; x index = step*3+elem.
  - After idx=8 -> WAIT, with all valids and data forced to 0 in the same cycle.
- Output data rule: whenever an in_valid is 0, its data port must be 0.
- cfg_we while busy=1 is ignored; start while busy=1 is ignored.
- WAIT:
  - lat counter increments each cycle.
  - out_valid=1 -> RECV; that word is stored as result[0].
  - lat reaching LAT_MAX with no out_valid -> err=1, FIN.
- RECV:
  - Stores out into result[ocnt] on each cycle out_valid=1.
  - out_valid must stay high for N_OUT consecutive cycles. A drop before 9 words -> err=1, FIN; words received so far are kept.
  - After the 9th word -> FIN.
- out_valid=1 during SEND -> err=1; finish the send, then FIN (skip WAIT/RECV).
- FIN: one cycle, done=1, busy drops to 0 next cycle, -> IDLE.
- rd_data is valid any time but is stable only when busy=0.
- Latency:
  - start at cycle t -> first in_valid at t+1, last in_valid at t+9.
  - done = 1 cycle after last result word.
- No arithmetic is performed on float words; they pass through bit-exact.

Test Plan:
- Load U=W=V=identity (0x3F800000 on diagonal, 0 elsewhere) and x all 0x40000000; start; NN model returns 9 words after 5 cycles.
  -> in_valid_* high for exactly 9 cycles, weight_u sequence 3F800000,0,0,0,3F800000,0,0,0,3F800000; results readable at rd_addr 0..8; done pulse; err=0.
- Out-of-band data check: sample all data ports while valids are low across the whole job.
  -> every data port reads 0.
- Timeout: NN model never asserts out_valid.
  -> done exactly LAT_MAX cycles after the last sent word; err=1; busy=0.
- Short burst: out_valid high 4 cycles, then low.
  -> err=1, done next cycle, result[0..3] captured, result[4..8] unchanged.
- start pulse and cfg_we during SEND.
  -> no restart; buffer contents unchanged; the next job resends the original words.
- rst_n low during RECV.
  -> all outputs 0 immediately; after release, state is IDLE and a fresh job completes normally.

Source files
------------

// File: rtl/nn_stream_driver.sv
// nn_stream_driver: initiator for the NN accelerator stream interface.
// Holds one RNN job (U, W, V weights and the x sequence), streams it into
// the NN core on start, then captures the NN result burst into a result
// buffer that the host reads combinationally.
module nn_stream_driver #(
  parameter int DW      = 32,
  parameter int N_IN    = 9,
  parameter int N_OUT   = 9,
  parameter int LAT_MAX = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_sel,
  input  logic [3:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic [3:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          in_valid_u,
  output logic          in_valid_w,
  output logic          in_valid_v,
  output logic          in_valid_x,
  output logic [DW-1:0] weight_u,
  output logic [DW-1:0] weight_w,
  output logic [DW-1:0] weight_v,
  output logic [DW-1:0] data_x,
  input  logic          out_valid,
  input  logic [DW-1:0] out
);

  localparam int LW = $clog2(LAT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, FIN} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    idx_reg, idx_next;
  logic [3:0]    ocnt_reg, ocnt_next;
  logic [LW-1:0] lat_reg, lat_next;
  logic          err_reg, err_next;

  // Job buffer: index 0..3 selects U, W, V, x; words are row-major.
  logic [DW-1:0] job_mem [4][N_IN];
  logic [DW-1:0] res_mem [N_OUT];
  logic [DW-1:0] stream_data [4];

  logic          cfg_ok;
  logic          res_we;
  logic [3:0]    res_addr;
  logic          send;

  // State register and job counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      ocnt_reg  <= '0;
      lat_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ocnt_reg  <= ocnt_next;
      lat_reg   <= lat_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic, buffer write enables and stream qualifier.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ocnt_next  = ocnt_reg;
    lat_next   = lat_reg;
    err_next   = err_reg;
    cfg_ok     = 1'b0;
    res_we     = 1'b0;
    res_addr   = ocnt_reg;
    send       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cfg_ok = cfg_we && (cfg_addr < 4'(N_IN));
        if (start) begin
          state_next = SEND;
          idx_next   = '0;
          ocnt_next  = '0;
          lat_next   = '0;
          err_next   = 1'b0;
        end
      end
      SEND: begin
        send = 1'b1;
        // NN talking while we are still sending is a protocol violation;
        // the send still completes but the receive phase is skipped.
        if (out_valid) err_next = 1'b1;
        if (idx_reg == 4'(N_IN - 1)) begin
          // lat counts cycles since the last sent word, so WAIT starts at 1.
          lat_next   = LW'(1);
          state_next = (err_reg || out_valid) ? FIN : WAIT;
        end else begin
          idx_next = idx_reg + 4'd1;
        end
      end
      WAIT: begin
        if (out_valid) begin
          res_we     = 1'b1;
          res_addr   = '0;
          ocnt_next  = 4'd1;
          state_next = RECV;
        end else if (lat_reg == LW'(LAT_MAX - 1)) begin
          err_next   = 1'b1;
          state_next = FIN;
        end else begin
          lat_next = lat_reg + LW'(1);
        end
      end
      RECV: begin
        if (out_valid) begin
          res_we    = 1'b1;
          ocnt_next = ocnt_reg + 4'd1;
          if (ocnt_reg == 4'(N_OUT - 1)) state_next = FIN;
        end else begin
          err_next   = 1'b1;
          state_next = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Host writes into the job buffer, accepted only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 4; s++)
        for (int a = 0; a < N_IN; a++)
          job_mem[s][a] <= '0;
    end else if (cfg_ok) begin
      job_mem[cfg_sel][cfg_addr] <= cfg_data;
    end
  end

  // Result capture; words beyond a short burst keep their old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < N_OUT; a++)
        res_mem[a] <= '0;
    end else if (res_we) begin
      res_mem[res_addr] <= out;
    end
  end

  // Data ports are forced to zero whenever the stream is not valid.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stream
      assign stream_data[gi] = send ? job_mem[gi][idx_reg] : '0;
    end
  endgenerate

  assign weight_u   = stream_data[0];
  assign weight_w   = stream_data[1];
  assign weight_v   = stream_data[2];
  assign data_x     = stream_data[3];
  assign in_valid_u = send;
  assign in_valid_w = send;
  assign in_valid_v = send;
  assign in_valid_x = send;
  assign busy       = (state_reg != IDLE);
  assign err        = err_reg;
  assign rd_data    = (rd_addr < 4'(N_OUT)) ? res_mem[rd_addr] : '0;

endmodule
